// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter: loads a WIDTH-bit word on a valid/ready handshake and
// streams it one bit per transfer, flagging the final bit with out_last.
module piso_serializer #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             serial_out,
  output logic             out_last,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    count_q, count_d;

  logic out_fire;
  logic load;

  assign busy      = (state_q == StShift);
  assign out_valid = busy;
  assign out_last  = busy & (count_q == '0);
  assign in_ready  = (state_q == StIdle) | (out_last & out_ready);
  assign out_fire  = out_valid & out_ready;
  assign load      = in_valid & in_ready;

  // The output end of the shift register drives the line directly; it is zero when idle.
  assign serial_out = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    if (load) begin
      // Covers both a fresh load from idle and a back-to-back reload on the last bit.
      state_d = StShift;
      shift_d = data_in;
      count_d = CW'(WIDTH - 1);
    end else if (out_fire) begin
      shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
      if (out_last) begin
        state_d = StIdle;
        count_d = '0;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: scoreboard of expected bits filled on word acceptance
// and drained on every serial transfer, plus cycle-level checks of the control outputs.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, out_ready;
  logic [3:0] data_in;
  logic       in_ready, out_valid, serial_out, out_last, busy;

  logic       l_in_valid, l_out_ready;
  logic [3:0] l_data_in;
  logic       l_in_ready, l_out_valid, l_serial_out, l_out_last, l_busy;

  int total = 0;
  int bad   = 0;
  bit sb[$];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in    (data_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .serial_out (serial_out),
    .out_last   (out_last),
    .busy       (busy)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (l_in_valid),
    .in_ready   (l_in_ready),
    .data_in    (l_data_in),
    .out_valid  (l_out_valid),
    .out_ready  (l_out_ready),
    .serial_out (l_serial_out),
    .out_last   (l_out_last),
    .busy       (l_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) sb.push_back(w[i]);
  endtask

  // Called at a negedge with inputs driven: score this cycle's transfers, then advance.
  task automatic tick();
    bit e;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_bit", 32'(serial_out), 32'hDEAD);
      end else begin
        e = sb.pop_front();
        chk("sb_bit", 32'(serial_out), 32'(e));
      end
    end
    if (in_valid && in_ready) push_word(data_in);
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    logic [3:0] lsb_exp;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; data_in = '0;
    l_in_valid = 1'b0; l_out_ready = 1'b1; l_data_in = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_serial_out", 32'(serial_out), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single word MSB first, full-rate sink.
    in_valid = 1'b1; data_in = 4'b1011;
    #1 chk("t2_in_ready_idle", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0; data_in = 4'h0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_out_valid", 32'(out_valid), 1);
      chk("t2_out_last", 32'(out_last), 32'(k == 3));
      chk("t2_in_ready", 32'(in_ready), 32'(k == 3));
      tick();
    end
    #1;
    chk("t2_idle_busy", 32'(busy), 0);
    chk("t2_idle_out_valid", 32'(out_valid), 0);
    chk("t2_sb_empty", 32'(sb.size()), 0);
    @(negedge clk);

    // Back-to-back words with in_valid held high.
    in_valid = 1'b1; data_in = 4'hA;
    tick();
    data_in = 4'h5;
    for (int k = 0; k < 8; k++) begin
      #1 chk("t3_out_valid", 32'(out_valid), 1);
      if (k == 3) chk("t3_reload_ready", 32'(in_ready), 1);
      if (k == 4) in_valid = 1'b0;
      tick();
    end
    #1;
    chk("t3_idle", 32'(out_valid), 0);
    chk("t3_sb_empty", 32'(sb.size()), 0);
    @(negedge clk);

    // Backpressure on bit 2 of 1011.
    in_valid = 1'b1; data_in = 4'b1011;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    tick(); cyc++;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_hold_serial", 32'(serial_out), 0);
      chk("t4_hold_last", 32'(out_last), 0);
      chk("t4_hold_valid", 32'(out_valid), 1);
      tick(); cyc++;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 10 && busy; k++) begin
      tick(); cyc++;
    end
    chk("t4_cycles", 32'(cyc), 7);
    chk("t4_sb_empty", 32'(sb.size()), 0);
    @(negedge clk);

    // Word offered while busy must be ignored.
    in_valid = 1'b1; data_in = 4'h0;
    tick();
    data_in = 4'hF;
    #1 chk("t6_in_ready_busy", 32'(in_ready), 0);
    tick();
    in_valid = 1'b0; data_in = 4'h0;
    for (int k = 0; k < 3; k++) tick();
    #1;
    chk("t6_idle_busy", 32'(busy), 0);
    chk("t6_sb_empty", 32'(sb.size()), 0);
    repeat (2) begin
      #1 chk("t6_no_extra", 32'(out_valid), 0);
      @(negedge clk);
    end

    // LSB-first instance.
    l_in_valid = 1'b1; l_data_in = 4'b0001;
    @(negedge clk);
    l_in_valid = 1'b0;
    lsb_exp = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t5_lsb_valid", 32'(l_out_valid), 1);
      chk("t5_lsb_bit", 32'(l_serial_out), 32'(lsb_exp[k]));
      chk("t5_lsb_last", 32'(l_out_last), 32'(k == 3));
      @(negedge clk);
    end
    #1 chk("t5_lsb_idle", 32'(l_busy), 0);
    @(negedge clk);

    // Asynchronous reset mid-word, after two bits of 1011.
    in_valid = 1'b1; data_in = 4'b1011;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    chk("t1_async_valid", 32'(out_valid), 0);
    chk("t1_async_serial", 32'(serial_out), 0);
    chk("t1_async_last", 32'(out_last), 0);
    chk("t1_async_busy", 32'(busy), 0);
    chk("t1_async_in_ready", 32'(in_ready), 1);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("t1_no_resume", 32'(out_valid), 0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
